key_debounce_arbiter: RTL and testbench

KEY_DEBOUNCE_ARBITER -- requirements
Module: key_debounce_arbiter

---
 rtl/key_arb_pkg.sv | 18 +
 rtl/key_rr_pick.sv | 35 +++
 rtl/key_debounce_arbiter.sv | 140 ++++++++++++++
 tb/tb_key_debounce_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_arb_pkg.sv
// Shared types and defaults for the debounced key arbiter: FSM state
// encoding and the default key count / debounce window length.
package key_arb_pkg;

    localparam int KEY_NUM_DEF   = 4;
    localparam int TIME_20MS_DEF = 1_000_000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        COUNT = ST_COUNT,
        DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/key_rr_pick.sv
// Combinational round-robin picker: returns the first pending key index
// strictly after last_grant, wrapping from KEY_NUM-1 back to 0.
module key_rr_pick
    import key_arb_pkg::*;
#(
    parameter int KEY_NUM = KEY_NUM_DEF
) (
    input  logic [KEY_NUM-1:0]         pending,
    input  logic [$clog2(KEY_NUM)-1:0] last_grant,
    output logic                       valid,
    output logic [$clog2(KEY_NUM)-1:0] index
);

    localparam int IDX_W = $clog2(KEY_NUM);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from the farthest candidate to the nearest so the nearest pending key wins.
    always_comb begin
        valid    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = KEY_NUM; k >= 1; k--) begin
            cand     = (int'(last_grant) + k) % KEY_NUM;
            cand_idx = IDX_W'(cand);
            if (pending[cand_idx]) begin
                valid = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/key_debounce_arbiter.sv
// Multi-key debouncer sharing a single window timer among all keys, granted
// round-robin. Optional macro DEBOUNCE_RESTART_EN restarts the window on re-bounce.
module key_debounce_arbiter
    import key_arb_pkg::*;
#(
    parameter int KEY_NUM   = KEY_NUM_DEF,
    parameter int TIME_20MS = TIME_20MS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [KEY_NUM-1:0]         key_in,
    output logic [KEY_NUM-1:0]         key_out,
    output logic [KEY_NUM-1:0]         key_press,
    output logic [KEY_NUM-1:0]         key_release,
    output logic                       busy,
    output logic [$clog2(KEY_NUM)-1:0] cur_key
);

    localparam int               IDX_W   = $clog2(KEY_NUM);
    localparam int               CNT_W   = $clog2(TIME_20MS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIME_20MS - 1);

    logic [KEY_NUM-1:0] key_r0_q, key_r0_d;
    logic [KEY_NUM-1:0] key_r1_q, key_r1_d;
    logic [KEY_NUM-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [IDX_W-1:0]   cur_key_q, cur_key_d;
    logic [KEY_NUM-1:0] key_out_q, key_out_d;
    logic [KEY_NUM-1:0] key_press_q, key_press_d;
    logic [KEY_NUM-1:0] key_release_q, key_release_d;

    logic [KEY_NUM-1:0] edge_det;
    logic [KEY_NUM-1:0] set_mask;
    logic [KEY_NUM-1:0] clr_mask;
    logic               restart;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_index;

    key_rr_pick #(
        .KEY_NUM (KEY_NUM)
    ) u_pick (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .index      (pick_index)
    );

    assign edge_det = key_r0_q ^ key_r1_q;

    always_comb begin
        key_r0_d      = key_in;
        key_r1_d      = key_r0_q;
        state_d       = state_q;
        counter_d     = counter_q;
        cur_key_d     = cur_key_q;
        last_grant_d  = last_grant_q;
        key_out_d     = key_out_q;
        key_press_d   = '0;
        key_release_d = '0;
        set_mask      = edge_det;
        clr_mask      = '0;
`ifdef DEBOUNCE_RESTART_EN
        // A bounce on the key being timed restarts its window instead of queueing it again.
        restart = (state_q == COUNT) && edge_det[cur_key_q];
        if (restart) begin
            set_mask[cur_key_q] = 1'b0;
        end
`else
        restart = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    cur_key_d            = pick_index;
                    clr_mask[pick_index] = 1'b1;
                    counter_d            = '0;
                    state_d              = COUNT;
                end
            end
            COUNT: begin
                if (restart) begin
                    counter_d = '0;
                end else if (counter_q == CNT_MAX) begin
                    state_d = DONE;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            DONE: begin
                key_out_d[cur_key_q]     = ~key_r1_q[cur_key_q];
                key_press_d[cur_key_q]   = ~key_out_q[cur_key_q] & ~key_r1_q[cur_key_q];
                key_release_d[cur_key_q] =  key_out_q[cur_key_q] &  key_r1_q[cur_key_q];
                last_grant_d             = cur_key_q;
                state_d                  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh edge wins over the grant clear so a bounce during grant is not lost.
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_r0_q      <= '1;
            key_r1_q      <= '1;
            pending_q     <= '0;
            counter_q     <= '0;
            state_q       <= IDLE;
            last_grant_q  <= IDX_W'(KEY_NUM - 1);
            cur_key_q     <= '0;
            key_out_q     <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
        end else begin
            key_r0_q      <= key_r0_d;
            key_r1_q      <= key_r1_d;
            pending_q     <= pending_d;
            counter_q     <= counter_d;
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cur_key_q     <= cur_key_d;
            key_out_q     <= key_out_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_out     = key_out_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign busy        = (state_q != IDLE);
    assign cur_key     = cur_key_q;

endmodule

// File: tb/tb_key_debounce_arbiter.sv
// Scoreboard bench for key_debounce_arbiter (KEY_NUM=4, TIME_20MS=8): directed
// key patterns push expected pulses; a monitor checks every pulse the DUT emits.
module tb_key_debounce_arbiter;

    localparam int KN  = 4;
    localparam int T20 = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [KN-1:0] keyIn;
    logic [KN-1:0] keyOut;
    logic [KN-1:0] keyPress;
    logic [KN-1:0] keyRelease;
    logic          busy;
    logic [1:0]    curKey;

    typedef struct {
        bit press;
        int idx;
        int cycle;
    } exp_t;

    exp_t          scoreQ[$];
    int            nChecks = 0;
    int            nPass   = 0;
    int            cyc     = 0;
    logic [KN-1:0] expOut  = '0;

    key_debounce_arbiter #(
        .KEY_NUM   (KN),
        .TIME_20MS (T20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (keyIn),
        .key_out     (keyOut),
        .key_press   (keyPress),
        .key_release (keyRelease),
        .busy        (busy),
        .cur_key     (curKey)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual == expected) nPass++;
        else $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic expectPulse(input bit press, input int idx, input int cycle);
        exp_t e;
        e.press = press;
        e.idx   = idx;
        e.cycle = cycle;
        scoreQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [KN-1:0] keys, output int drvCyc);
        @(negedge clk);
        keyIn  = keys;
        drvCyc = cyc;
    endtask

    task automatic waitToCycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drainCheck(input string name, input int limit);
        int k = 0;
        while (scoreQ.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        checkOutput({name, " queue empty"}, scoreQ.size(), 0);
        checkOutput({name, " busy idle"}, busy, 0);
    endtask

    task automatic scorePulse(input bit press, input int idx);
        exp_t e;
        checkOutput($sformatf("pulse expected %s key%0d", press ? "press" : "release", idx),
                    (scoreQ.size() > 0) ? 1 : 0, 1);
        if (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            checkOutput("pulse kind", press, e.press);
            checkOutput("pulse key", idx, e.idx);
            checkOutput("pulse cycle", cyc, e.cycle);
            expOut[e.idx] = e.press;
        end
    endtask

    // Monitor: every pulse on key_press/key_release must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            expOut = '0;
        end else if ((keyPress | keyRelease) != '0) begin
            for (int i = 0; i < KN; i++) begin
                if (keyPress[i])   scorePulse(1'b1, i);
                if (keyRelease[i]) scorePulse(1'b0, i);
            end
            checkOutput("key_out at pulse", keyOut, expOut);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        keyIn = '1;
        repeat (3) @(negedge clk);
        checkOutput("reset key_out", keyOut, 0);
        checkOutput("reset key_press", keyPress, 0);
        checkOutput("reset key_release", keyRelease, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset cur_key", curKey, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Keys 0,1,3 fall together: service order 0,1,3, pulses 10 cycles apart.
        applyStimulus(4'b0100, n);
        expectPulse(1'b1, 0, n + 12);
        expectPulse(1'b1, 1, n + 22);
        expectPulse(1'b1, 3, n + 32);
        waitToCycle(n + 3);
        checkOutput("simul busy", busy, 1);
        checkOutput("simul cur_key first", curKey, 0);
        waitToCycle(n + 13);
        checkOutput("simul cur_key second", curKey, 1);
        waitToCycle(n + 23);
        checkOutput("simul cur_key third", curKey, 3);
        waitToCycle(n + 40);
        drainCheck("simul press", 20);

        applyStimulus(4'b1111, n);
        expectPulse(1'b0, 0, n + 12);
        expectPulse(1'b0, 1, n + 22);
        expectPulse(1'b0, 3, n + 32);
        waitToCycle(n + 40);
        drainCheck("simul release", 20);

        // Single press on key 2 with busy window checks.
        applyStimulus(4'b1011, n);
        expectPulse(1'b1, 2, n + 12);
        waitToCycle(n + 2);
        checkOutput("single busy before", busy, 0);
        waitToCycle(n + 3);
        checkOutput("single busy start", busy, 1);
        checkOutput("single cur_key", curKey, 2);
        waitToCycle(n + 11);
        checkOutput("single busy end", busy, 1);
        waitToCycle(n + 12);
        checkOutput("single busy after", busy, 0);
        checkOutput("single key_out", keyOut, 4'b0100);
        waitToCycle(n + 20);
        drainCheck("single press", 20);

        applyStimulus(4'b1111, n);
        expectPulse(1'b0, 2, n + 12);
        waitToCycle(n + 20);
        drainCheck("single release", 20);
        checkOutput("release key_out", keyOut, 0);

        // Fairness: key 1 in service while 0 and 2 queue up; key 2 must go before key 0.
        applyStimulus(4'b1101, n);
        expectPulse(1'b1, 1, n + 12);
        waitToCycle(n + 5);
        keyIn = 4'b1000;
        expectPulse(1'b1, 2, n + 22);
        expectPulse(1'b1, 0, n + 32);
        waitToCycle(n + 14);
        checkOutput("fair cur_key after key1", curKey, 2);
        waitToCycle(n + 24);
        checkOutput("fair cur_key last", curKey, 0);
        waitToCycle(n + 40);
        drainCheck("fair press", 20);

        applyStimulus(4'b1111, n);
        expectPulse(1'b0, 1, n + 12);
        expectPulse(1'b0, 2, n + 22);
        expectPulse(1'b0, 0, n + 32);
        waitToCycle(n + 40);
        drainCheck("fair release", 20);

        // Bounce on key 1: exactly one press, no release, key ends pressed.
        applyStimulus(4'b1101, n);
        waitToCycle(n + 1);
        keyIn = 4'b1111;
        waitToCycle(n + 3);
        keyIn = 4'b1101;
`ifdef DEBOUNCE_RESTART_EN
        expectPulse(1'b1, 1, n + 14);
`else
        expectPulse(1'b1, 1, n + 12);
`endif
        waitToCycle(n + 13);
        checkOutput("bounce busy reservice", busy, 1);
        waitToCycle(n + 40);
        drainCheck("bounce", 20);
        checkOutput("bounce key_out", keyOut, 4'b0010);

        // Reset while key 3 is mid-window (counter = 4).
        applyStimulus(4'b0101, n);
        waitToCycle(n + 7);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset key_out", keyOut, 0);
        checkOutput("midreset key_press", keyPress, 0);
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset cur_key", curKey, 0);
        keyIn = '1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("post reset busy", busy, 0);
        checkOutput("post reset key_out", keyOut, 0);

        applyStimulus(4'b1110, n);
        expectPulse(1'b1, 0, n + 12);
        waitToCycle(n + 3);
        checkOutput("post reset cur_key", curKey, 0);
        waitToCycle(n + 20);
        drainCheck("post reset press", 20);
        checkOutput("post reset final key_out", keyOut, 4'b0001);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
